// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter/receiver pair.
package uart_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 16;
    localparam logic LINE_IDLE            = 1'b1;
    localparam int   DATA_BITS            = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_ARMED,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_txrx_if.sv
// Client/pin-side bundle of the UART: byte ports, control, status and serial pins.
interface uart_txrx_if;
    import uart_pkg::*;

    logic                 tx_en;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_in;
    logic                 tx_out;
    logic                 tx_done;
    logic                 tx_busy;
    logic                 rx_en;
    logic                 rx_in;
    logic                 rx_start;
    logic [DATA_BITS-1:0] rx_out;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 rx_err;

    modport master (
        output tx_en, tx_start, tx_in, rx_en, rx_in, rx_start,
        input  tx_out, tx_done, tx_busy, rx_out, rx_done, rx_busy, rx_err
    );

    modport slave (
        input  tx_en, tx_start, tx_in, rx_en, rx_in, rx_start,
        output tx_out, tx_done, tx_busy, rx_out, rx_done, rx_busy, rx_err
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 deserialiser: armed by a start request, samples each bit at mid-bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic                 line_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 sync1_q, sync2_q;
    logic                 rxBit;

    assign rxBit = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= LINE_IDLE;
            sync2_q  <= LINE_IDLE;
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= line_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // A start bit that is high again at its midpoint was a glitch: re-arm silently.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        done_d   = done_q;
        busy_d   = busy_q;
        err_d    = err_q;

        case (state_q)
            RX_IDLE: begin
                if (en_i && start_i) begin
                    state_d = RX_ARMED;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            RX_ARMED: begin
                cnt_d = '0;
                if (rxBit == ~LINE_IDLE) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = (rxBit == LINE_IDLE) ? RX_ARMED : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxBit, shift_q[DATA_BITS-1:1]};
                    if (bitIdx_q == 3'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    data_d  = shift_q;
                    done_d  = 1'b1;
                    err_d   = (rxBit != LINE_IDLE);
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o = data_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: START/DATA/STOP each held CLKS_PER_BIT cycles, LSB first.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 line_o,
    output logic                 done_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 line_q, line_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= TX_IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            line_q   <= LINE_IDLE;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            line_q   <= line_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Outputs are registered from the current state, so the pin and flags
    // trail the FSM by one cycle and stay glitch-free.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        line_d   = LINE_IDLE;
        busy_d   = (state_q != TX_IDLE);
        done_d   = (state_q == TX_IDLE) ? (done_q | busy_q) : 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (en_i && start_i) begin
                    state_d = TX_START;
                    shift_d = data_i;
                    cnt_d   = '0;
                end
            end
            TX_START: begin
                line_d = ~LINE_IDLE;
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = TX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                line_d = shift_q[0];
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bitIdx_q == 3'(DATA_BITS - 1)) begin
                        state_d = TX_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign line_o = line_q;
    assign done_o = done_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver on one clock.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input logic       clk,
    input logic       rst,
    uart_txrx_if.slave bus
);

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.tx_en),
        .start_i(bus.tx_start),
        .data_i (bus.tx_in),
        .line_o (bus.tx_out),
        .done_o (bus.tx_done),
        .busy_o (bus.tx_busy)
    );

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.rx_en),
        .start_i(bus.rx_start),
        .line_i (bus.rx_in),
        .data_o (bus.rx_out),
        .done_o (bus.rx_done),
        .busy_o (bus.rx_busy),
        .err_o  (bus.rx_err)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: loopback frames, framing error, glitch and reset abort.
module tb_uart_txrx;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst;
    logic loopback;
    logic rxDrive;
    int   vecCount = 0;
    int   errCount = 0;

    uart_txrx_if bus ();

    assign bus.rx_in = loopback ? bus.tx_out : rxDrive;

    uart_txrx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic txEn, input logic txStart, input logic [7:0] txData,
                                 input logic rxEn, input logic rxStart);
        bus.tx_en    = txEn;
        bus.tx_start = txStart;
        bus.tx_in    = txData;
        bus.rx_en    = rxEn;
        bus.rx_start = rxStart;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic driveRxBit(input logic b);
        rxDrive = b;
        stepCycles(CPB);
    endtask

    initial begin
        logic [7:0] errByte;
        errByte = 8'h5A;

        rst      = 1'b1;
        loopback = 1'b1;
        rxDrive  = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        stepCycles(3);
        checkOutput("rst_tx_out",  8'(bus.tx_out),  8'h01);
        checkOutput("rst_tx_done", 8'(bus.tx_done), 8'h00);
        checkOutput("rst_tx_busy", 8'(bus.tx_busy), 8'h00);
        checkOutput("rst_rx_done", 8'(bus.rx_done), 8'h00);
        checkOutput("rst_rx_busy", 8'(bus.rx_busy), 8'h00);
        checkOutput("rst_rx_err",  8'(bus.rx_err),  8'h00);
        checkOutput("rst_rx_out",  bus.rx_out,      8'h00);
        rst = 1'b0;
        stepCycles(1);

        // tx_start while disabled must be ignored
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        stepCycles(2);
        checkOutput("dis_tx_busy", 8'(bus.tx_busy), 8'h00);
        stepCycles(CPB);
        checkOutput("dis_tx_out",  8'(bus.tx_out),  8'h01);
        checkOutput("dis_tx_done", 8'(bus.tx_done), 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        stepCycles(2);

        // Loopback 8'hAA; enables dropped right after acceptance (edge N)
        applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("aa_start_bit", 8'(bus.tx_out),  8'h00);
        checkOutput("aa_tx_busy",   8'(bus.tx_busy), 8'h01);
        checkOutput("aa_rx_busy",   8'(bus.rx_busy), 8'h01);
        stepCycles(CPB + CPB / 2);
        checkOutput("aa_bit0", 8'(bus.tx_out), 8'h00);
        stepCycles(CPB);
        checkOutput("aa_bit1", 8'(bus.tx_out), 8'h01);
        stepCycles(10 * CPB - 1 - (5 * CPB) / 2);
        checkOutput("aa_tx_done_early", 8'(bus.tx_done), 8'h00);
        checkOutput("aa_tx_busy_late",  8'(bus.tx_busy), 8'h01);
        checkOutput("aa_rx_done_first", 8'(bus.rx_done), 8'h01);
        stepCycles(1);
        checkOutput("aa_tx_done",  8'(bus.tx_done), 8'h01);
        checkOutput("aa_tx_idle",  8'(bus.tx_busy), 8'h00);
        checkOutput("aa_rx_out",   bus.rx_out,      8'hAA);
        checkOutput("aa_rx_err",   8'(bus.rx_err),  8'h00);
        checkOutput("aa_rx_idle",  8'(bus.rx_busy), 8'h00);

        // Back-to-back 8'h00 then 8'hFF with both starts held high
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        stepCycles(1);
        checkOutput("b2b_done_cleared", 8'(bus.tx_done), 8'h00);
        checkOutput("b2b_start_bit",    8'(bus.tx_out),  8'h00);
        stepCycles(10 * CPB);
        checkOutput("b2b_first_tx_done", 8'(bus.tx_done), 8'h01);
        checkOutput("b2b_first_rx_out",  bus.rx_out,      8'h00);
        checkOutput("b2b_rx_rearmed",    8'(bus.rx_busy), 8'h01);
        checkOutput("b2b_rx_done_clr",   8'(bus.rx_done), 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        stepCycles(10 * CPB);
        checkOutput("b2b_second_early", 8'(bus.tx_done), 8'h00);
        stepCycles(1);
        checkOutput("b2b_second_tx_done", 8'(bus.tx_done), 8'h01);
        checkOutput("b2b_second_tx_busy", 8'(bus.tx_busy), 8'h00);
        checkOutput("b2b_second_rx_done", 8'(bus.rx_done), 8'h01);
        checkOutput("b2b_second_rx_out",  bus.rx_out,      8'hFF);
        checkOutput("b2b_second_rx_err",  8'(bus.rx_err),  8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        stepCycles(2);

        // Directly driven 8'h5A with the stop bit held low
        loopback = 1'b0;
        rxDrive  = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        stepCycles(2);
        checkOutput("ferr_armed",     8'(bus.rx_busy), 8'h01);
        checkOutput("ferr_done_clr",  8'(bus.rx_done), 8'h00);
        driveRxBit(1'b0);
        for (int i = 0; i < 8; i++) driveRxBit(errByte[i]);
        driveRxBit(1'b0);
        checkOutput("ferr_rx_done", 8'(bus.rx_done), 8'h01);
        checkOutput("ferr_rx_err",  8'(bus.rx_err),  8'h01);
        checkOutput("ferr_rx_out",  bus.rx_out,      8'h5A);
        checkOutput("ferr_rx_busy", 8'(bus.rx_busy), 8'h00);
        rxDrive = 1'b1;
        stepCycles(CPB);

        // Short low glitch while armed must be rejected
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        stepCycles(2);
        rxDrive = 1'b0;
        stepCycles(CPB / 2 - 2);
        rxDrive = 1'b1;
        stepCycles(2 * CPB);
        checkOutput("glitch_rx_done", 8'(bus.rx_done), 8'h00);
        checkOutput("glitch_rx_err",  8'(bus.rx_err),  8'h00);
        checkOutput("glitch_rearmed", 8'(bus.rx_busy), 8'h01);

        // Reset during DATA of both TX and RX
        loopback = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        stepCycles(1 + CPB + CPB / 2);
        checkOutput("mid_tx_out",  8'(bus.tx_out),  8'h00);
        checkOutput("mid_tx_busy", 8'(bus.tx_busy), 8'h01);
        rst = 1'b1;
        stepCycles(1);
        checkOutput("abort_tx_out",  8'(bus.tx_out),  8'h01);
        checkOutput("abort_tx_busy", 8'(bus.tx_busy), 8'h00);
        checkOutput("abort_tx_done", 8'(bus.tx_done), 8'h00);
        checkOutput("abort_rx_busy", 8'(bus.rx_busy), 8'h00);
        checkOutput("abort_rx_done", 8'(bus.rx_done), 8'h00);
        checkOutput("abort_rx_err",  8'(bus.rx_err),  8'h00);
        checkOutput("abort_rx_out",  bus.rx_out,      8'h00);
        rst = 1'b0;
        stepCycles(2 * CPB);
        checkOutput("post_abort_tx_out",  8'(bus.tx_out),  8'h01);
        checkOutput("post_abort_tx_busy", 8'(bus.tx_busy), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
# uart_txrx

Full-duplex 8N1 UART block: one transmitter and one receiver sharing a single clock, with independent enable/start controls and status flags. It sits between a byte-level client and the serial pins. The client writes bytes through the TX port and collects received bytes, with framing-error status, from the RX port. For loopback testing, `tx_out` is wired externally to `rx_in`.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be an even value of at least 4.
- `clk` in 1: single system clock; all logic updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_en` in 1: transmitter enable; gates acceptance of `tx_start`.
- `tx_start` in 1: level-sampled request to send `tx_in`.
- `tx_in` in 8: byte to transmit, latched when the frame is accepted.
- `tx_out` out 1: serial output; idles high.
- `tx_done` out 1: sticky flag meaning the last frame completed.
- `tx_busy` out 1: high while a frame is being transmitted.
- `rx_en` in 1: receiver enable; gates acceptance of `rx_start`.
- `rx_in` in 1: serial input (asynchronous).
- `rx_start` in 1: arms the receiver to capture one frame.
- `rx_out` out 8: last received byte.
- `rx_done` out 1: sticky flag meaning a frame has been received.
- `rx_busy` out 1: high while the receiver is armed or receiving.
- `rx_err` out 1: sticky framing-error flag for the last frame.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Reset values: `tx_out`=1; `rx_out`=0; all other outputs 0. Both FSMs return to IDLE and counters clear. Reset in the middle of a frame aborts that frame immediately.
- TX FSM has states IDLE, START, DATA, STOP.
  - IDLE → START when `tx_en & tx_start`. On that transition: latch `tx_in`, set `tx_busy`, clear `tx_done`.
  - START, DATA and STOP each hold `tx_out` for `CLKS_PER_BIT` cycles per bit.
  - STOP → IDLE: set `tx_done`, clear `tx_busy`.
  - A `tx_start` still high in IDLE starts a new frame on the next cycle. `tx_start` outside IDLE is ignored.
  - Deasserting `tx_en` in the middle of a frame does not abort it; `tx_en` only gates acceptance.
- RX input conditioning: `rx_in` passes through a 2-flop synchronizer before any use.
- RX FSM has states IDLE, ARMED, START, DATA, STOP.
  - IDLE → ARMED when `rx_en & rx_start`. On that transition: set `rx_busy`; clear `rx_done` and `rx_err`.
  - ARMED → START on a synchronized low level.
  - START: wait `CLKS_PER_BIT/2` cycles, then resample. If the line is high, treat it as a glitch and return to ARMED with no error. If it is low, go to DATA.
  - DATA: sample each data bit at mid-bit, every `CLKS_PER_BIT` cycles, shifting LSB first.
  - STOP: sample at mid-bit, then return to IDLE. On this transition: update `rx_out`, set `rx_done`, set `rx_err` if the stop sample is 0, and clear `rx_busy`.
  - `rx_start` outside IDLE is ignored. Deasserting `rx_en` does not abort a frame already in progress.
- Flag behaviour: done and err flags are level-held (sticky) until the next accepted start or `rst`. A client may therefore check them at any time after completion.

## Timing
- TX timing, with `tx_start` accepted at edge N:
  - `tx_out` goes low at edge N+1.
  - Data bit k occupies the cycles from N+1+(k+1)·CPB.
  - The stop bit begins at N+1+9·CPB.
  - `tx_done` rises and `tx_busy` falls at edge N+1+10·CPB.
- RX latency:
  - Synchronizer adds 2 cycles.
  - The stop sample is taken about 9.5·CPB + 3 cycles after the falling edge of the start bit.
  - `rx_done` therefore rises before the transmitter's `tx_done` in loopback.
- A new TX start is accepted at the earliest 1 cycle after `tx_done` rises; back-to-back frames have no extra idle bit.
- Bit counters are wide enough for `CLKS_PER_BIT-1` and wrap to 0 at the end of each bit.

## Structure
- Shared package `uart_pkg` holds:
  - the TX and RX state enums;
  - the default `CLKS_PER_BIT`;
  - `LINE_IDLE`=1, `DATA_BITS`=8.
- Top-level `uart_txrx` instantiates the two sub-modules `uart_tx` and `uart_rx`, each with its own `clk`/`rst`. There is no shared state between them.

## Test plan
- Loopback of 8'hAA with `tx_en`, `rx_en`, `tx_start` and `rx_start` pulsed together:
  - `tx_done`=1 at N+1+10·CPB;
  - `rx_done`=1, `rx_out`=8'hAA, `rx_err`=0;
  - both busy flags = 0.
- Loopback of 8'h00, then 8'hFF back-to-back with `tx_start` held high: two frames, 20·CPB total, `rx_out` ends at 8'hFF.
- Directly drive `rx_in` with a valid start bit and data 8'h5A, then hold the line low through the stop bit: `rx_done`=1, `rx_err`=1, `rx_out`=8'h5A.
- `tx_start`=1 with `tx_en`=0: `tx_out` stays 1, `tx_busy` stays 0, `tx_done` stays 0.
- Low glitch on `rx_in` of `CLKS_PER_BIT/2 - 2` cycles while ARMED: the FSM returns to ARMED, `rx_done`=0, `rx_err`=0.
- `rst` asserted during the DATA state of TX and RX: the next cycle shows `tx_out`=1 and all flags 0.
